// File: rtl/addr_dec_req_bridge_ot_if.sv
// Request-side bundle between a master port, the decoder bridge
// and the per-slave arbitration trees.
interface addr_dec_req_bridge_ot_if #(
  parameter int ID_WIDTH  = 17,
  parameter int N_SLAVE   = 16,
  parameter int CNT_WIDTH = 3
);
  logic                 data_req_i;
  logic [N_SLAVE-1:0]   destination_i;
  logic                 data_gnt_o;
  logic [N_SLAVE-1:0]   data_gnt_i;
  logic [N_SLAVE-1:0]   data_req_o;
  logic [ID_WIDTH-1:0]  data_ID_o;
  logic                 data_r_valid_i;
  logic [CNT_WIDTH-1:0] outstanding_o;
  logic                 busy_o;
  logic                 err_valid_o;

  modport master (
    output data_req_i, destination_i,
    output data_gnt_i, data_r_valid_i,
    input  data_gnt_o, data_req_o, data_ID_o,
    input  outstanding_o, busy_o, err_valid_o
  );

  modport slave (
    input  data_req_i, destination_i,
    input  data_gnt_i, data_r_valid_i,
    output data_gnt_o, data_req_o, data_ID_o,
    output outstanding_o, busy_o, err_valid_o
  );
endinterface

// File: rtl/addr_dec_req_bridge_ot.sv
// One-hot request fan-out with an ordering lock on outstanding responses.
// BRIDGE_ERR_RESP_EN: unmapped requests are answered locally via err_valid_o.
module addr_dec_req_bridge_ot #(
  parameter int ID_WIDTH        = 17,
  parameter int ID              = 1,
  parameter int N_SLAVE         = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING+1)
) (
  input logic clk,
  input logic rst,
  addr_dec_req_bridge_ot_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    FULL
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(MAX_OUTSTANDING);

  state_e               state;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [N_SLAVE-1:0]   last_dest_q, last_dest_d;
  logic                 err_valid_q, err_valid_d;
  logic                 stall;
  logic                 err_req;
  logic                 gnt;
  logic                 inc;
  logic                 dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      last_dest_q <= '0;
      err_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      last_dest_q <= last_dest_d;
      err_valid_q <= err_valid_d;
    end
  end

  always_comb begin
    state = IDLE;
    if (cnt_q == CNT_MAX)
      state = FULL;
    else if (cnt_q != '0)
      state = LOCKED;
  end

  always_comb begin
    err_req     = 1'b0;
    stall       = 1'b0;
    gnt         = 1'b0;
    inc         = 1'b0;
    dec         = 1'b0;
    err_valid_d = 1'b0;
    last_dest_d = last_dest_q;
    cnt_d       = cnt_q;
`ifdef BRIDGE_ERR_RESP_EN
    err_req = bus.data_req_i && (bus.destination_i == '0);
`endif
    unique case (1'b1)
      state == FULL:   stall = 1'b1;
      state == LOCKED: stall = err_req ||
                         (bus.destination_i != last_dest_q);
      default:         stall = 1'b0;
    endcase
    gnt = bus.data_req_i && !stall &&
          ((|(bus.data_gnt_i & bus.destination_i)) || err_req);
    // Locally answered requests never reach a slave, so never count.
    inc         = gnt && !err_req;
    dec         = bus.data_r_valid_i && (cnt_q != '0);
    err_valid_d = gnt && err_req;
    if (gnt)
      last_dest_d = bus.destination_i;
    cnt_d = cnt_q + CNT_WIDTH'(inc) - CNT_WIDTH'(dec);
  end

  assign bus.data_req_o =
    {N_SLAVE{bus.data_req_i & ~stall}} & bus.destination_i;
  assign bus.data_gnt_o    = gnt;
  assign bus.data_ID_o     = ID_WIDTH'(ID);
  assign bus.outstanding_o = cnt_q;
  assign bus.busy_o        = (cnt_q != '0);
`ifdef BRIDGE_ERR_RESP_EN
  assign bus.err_valid_o   = err_valid_q;
`else
  assign bus.err_valid_o   = 1'b0;
`endif

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.data_r_valid_i && cnt_q == '0))
        else $error("response with no outstanding request");
      assert (!(bus.data_req_i && !$onehot0(bus.destination_i)))
        else $error("multi-hot destination");
    end
  end

endmodule
